// File: rtl/right_shift_iterative.sv
// Multicycle right shifter: shifts an operand right by up to 2**SHAMT_WIDTH-1 bits,
// two bits per cycle, with logical or arithmetic fill and a start/ready handshake.
module right_shift_iterative #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ctrl_start,
    input  logic                   ctrl_arith,
    input  logic [SHAMT_WIDTH-1:0] ctrl_shiftamt,
    input  logic [DATA_WIDTH-1:0]  data_operand,
    output logic [DATA_WIDTH-1:0]  data_result,
    output logic                   data_busy,
    output logic                   data_resultRDY
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [SHAMT_WIDTH-1:0] TWO = SHAMT_WIDTH'(2);

    state_t                 state_r;
    state_t                 state_s;
    logic [SHAMT_WIDTH-1:0] count_r;
    logic [SHAMT_WIDTH-1:0] count_dec_s;
    logic [DATA_WIDTH-1:0]  result_r;
    logic [DATA_WIDTH-1:0]  shifted_s;
    logic                   fill_r;
    logic                   busy_r;
    logic                   busy_s;
    logic                   rdy_r;
    logic                   rdy_s;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // One shift step: two bits while at least two remain, otherwise the final odd bit.
    always_comb begin
        shifted_s   = result_r;
        count_dec_s = count_r;
        if (count_r >= TWO) begin
            shifted_s   = {fill_r, fill_r, result_r[DATA_WIDTH-1:2]};
            count_dec_s = count_r - TWO;
        end else begin
            shifted_s   = {fill_r, result_r[DATA_WIDTH-1:1]};
            count_dec_s = '0;
        end
    end

    // Next-state logic; a zero shift amount goes straight to DONE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ctrl_start) begin
                    state_s = (ctrl_shiftamt == '0) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (count_dec_s == '0) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so busy/ready can be registered without extra latency.
    always_comb begin
        busy_s = 1'b0;
        rdy_s  = 1'b0;
        case (state_s)
            ST_IDLE: begin
                busy_s = 1'b0;
                rdy_s  = 1'b0;
            end
            ST_SHIFT: begin
                busy_s = 1'b1;
                rdy_s  = 1'b0;
            end
            ST_DONE: begin
                busy_s = 1'b1;
                rdy_s  = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
                rdy_s  = 1'b0;
            end
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_r <= 1'b0;
            rdy_r  <= 1'b0;
        end else begin
            busy_r <= busy_s;
            rdy_r  <= rdy_s;
        end
    end

    // Datapath: capture on an accepted start, step while shifting, otherwise hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_r <= '0;
            count_r  <= '0;
            fill_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ctrl_start) begin
                        result_r <= data_operand;
                        count_r  <= ctrl_shiftamt;
                        fill_r   <= ctrl_arith & data_operand[DATA_WIDTH-1];
                    end else begin
                        result_r <= result_r;
                        count_r  <= count_r;
                        fill_r   <= fill_r;
                    end
                end
                ST_SHIFT: begin
                    result_r <= shifted_s;
                    count_r  <= count_dec_s;
                end
                default: begin
                    result_r <= result_r;
                    count_r  <= count_r;
                    fill_r   <= fill_r;
                end
            endcase
        end
    end

    assign data_result    = result_r;
    assign data_busy      = busy_r;
    assign data_resultRDY = rdy_r;

endmodule
